// File: rtl/hit_judge.sv
// Per-lane press/note timing judge with combo-multiplied saturating score.
// Every output is registered, so a judgement appears one cycle after its inputs.
module hit_judge #(
  parameter int LANES   = 4,
  parameter int WINDOW  = 8,
  parameter int HIT_PTS = 10,
  parameter int SCORE_W = 16,
  parameter int COMBO_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES-1:0]   press,
  input  logic [LANES-1:0]   note_due,
  output logic [LANES-1:0]   hit_pulse,
  output logic [LANES-1:0]   miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int CNT_W = $clog2(LANES + 1);
  localparam int AW    = 32;
  localparam logic [WIN_W-1:0] WMAX = WIN_W'(WINDOW - 1);

  typedef enum logic {
    IDLE,
    ARMED
  } state_e;

  state_e           st_q  [LANES];
  state_e           st_d  [LANES];
  logic [WIN_W-1:0] win_q [LANES];
  logic [WIN_W-1:0] win_d [LANES];

  logic [LANES-1:0]   hit_q, hit_d;
  logic [LANES-1:0]   miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;

  logic [CNT_W-1:0]   h_cnt;
  logic [COMBO_W-1:0] c_shr;
  logic [2:0]         mult;
  logic [AW-1:0]      add_w;
  logic [AW-1:0]      sum_w;
  logic [COMBO_W:0]   c_sum;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      st_d[i]   = st_q[i];
      win_d[i]  = win_q[i];
      hit_d[i]  = 1'b0;
      miss_d[i] = 1'b0;
      unique case (st_q[i])
        IDLE: begin
          if (note_due[i] && press[i]) begin
            hit_d[i] = 1'b1;
          end else if (note_due[i]) begin
            st_d[i]  = ARMED;
            win_d[i] = WMAX;
          end else if (press[i]) begin
            miss_d[i] = 1'b1;
          end
        end
        ARMED: begin
          // A fresh note always restarts the window, even on a hit.
          if (press[i] && note_due[i]) begin
            hit_d[i] = 1'b1;
            win_d[i] = WMAX;
          end else if (press[i]) begin
            hit_d[i] = 1'b1;
            st_d[i]  = IDLE;
          end else if (note_due[i]) begin
            miss_d[i] = 1'b1;
            win_d[i]  = WMAX;
          end else if (win_q[i] == '0) begin
            miss_d[i] = 1'b1;
            st_d[i]   = IDLE;
          end else begin
            win_d[i] = win_q[i] - 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    h_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      h_cnt = h_cnt + CNT_W'(hit_d[i]);
    end
    c_shr = combo_q >> 3;
    mult  = (c_shr >= COMBO_W'(3)) ? 3'd4 : 3'(c_shr) + 3'd1;
    add_w = AW'(h_cnt) * AW'(HIT_PTS) * AW'(mult);
    sum_w = AW'(score_q) + add_w;
    c_sum = {1'b0, combo_q} + (COMBO_W+1)'(h_cnt);

    score_d = (sum_w[AW-1:SCORE_W] != '0) ? '1 : sum_w[SCORE_W-1:0];
    if (|miss_d) begin
      combo_d = '0;
    end else begin
      combo_d = c_sum[COMBO_W] ? '1 : c_sum[COMBO_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]  <= IDLE;
        win_q[i] <= '0;
      end
      hit_q   <= '0;
      miss_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]  <= st_d[i];
        win_q[i] <= win_d[i];
      end
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign combo      = combo_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed and random press/note traffic,
// deadline-based reference model feeding a queue checked by a monitor.
module tb_hit_judge;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int PT = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [L-1:0] press = '0;
  logic [L-1:0] note_due = '0;
  logic [L-1:0] hit_pulse;
  logic [L-1:0] miss_pulse;
  logic [15:0]  score;
  logic [7:0]   combo;

  hit_judge dut (
    .clk        (clk),
    .reset      (reset),
    .press      (press),
    .note_due   (note_due),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .combo      (combo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0] hit;
    logic [L-1:0] miss;
    logic [15:0]  score;
    logic [7:0]   combo;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // reference state: a pending note per lane and the last cycle it may be hit
  bit pend [L];
  int dline [L];
  int m_score = 0;
  int m_combo = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, req, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      pend[i]  = 0;
      dline[i] = 0;
    end
    m_score = 0;
    m_combo = 0;
  endtask

  task automatic model(input logic [L-1:0] p, input logic [L-1:0] n);
    exp_t e;
    int h, m, mul;
    h = 0;
    m = 0;
    e.hit  = '0;
    e.miss = '0;
    for (int i = 0; i < L; i++) begin
      if (pend[i]) begin
        if (p[i]) begin
          e.hit[i] = 1'b1;
          if (n[i]) dline[i] = cyc + W;
          else pend[i] = 0;
        end else if (n[i]) begin
          e.miss[i] = 1'b1;
          dline[i] = cyc + W;
        end else if (cyc == dline[i]) begin
          e.miss[i] = 1'b1;
          pend[i] = 0;
        end
      end else begin
        if (n[i] && p[i]) e.hit[i] = 1'b1;
        else if (n[i]) begin
          pend[i]  = 1;
          dline[i] = cyc + W;
        end else if (p[i]) e.miss[i] = 1'b1;
      end
      h += int'(e.hit[i]);
      m += int'(e.miss[i]);
    end
    mul = 1 + m_combo / 8;
    if (mul > 4) mul = 4;
    m_score += h * PT * mul;
    if (m_score > 65535) m_score = 65535;
    if (m > 0) m_combo = 0;
    else begin
      m_combo += h;
      if (m_combo > 255) m_combo = 255;
    end
    e.score = 16'(m_score);
    e.combo = 8'(m_combo);
    q.push_back(e);
    cyc++;
  endtask

  task automatic step(input logic [L-1:0] p, input logic [L-1:0] n);
    @(negedge clk);
    press    = p;
    note_due = n;
    model(p, n);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step('0, '0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".hit"},   int'(hit_pulse),  0);
    chk({nm, ".miss"},  int'(miss_pulse), 0);
    chk({nm, ".score"}, int'(score),      0);
    chk({nm, ".combo"}, int'(combo),      0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hit_pulse",  int'(hit_pulse),  int'(e.hit));
      chk("miss_pulse", int'(miss_pulse), int'(e.miss));
      chk("score",      int'(score),      int'(e.score));
      chk("combo",      int'(combo),      int'(e.combo));
    end
  end

  initial begin
    model_reset();
    #12;
    chk_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // single note then press three cycles later
    step('0, 4'b0001);
    idle(2);
    step(4'b0001, '0);
    idle(3);

    // note expiring, press on last window cycle, press one cycle too late
    step('0, 4'b0010);
    idle(W + 2);
    step('0, 4'b0010);
    idle(W - 1);
    step(4'b0010, '0);
    idle(2);
    step('0, 4'b0010);
    idle(W);
    step(4'b0010, '0);
    idle(2);

    // combo of 5, then stray press resets it
    for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001);
    step(4'b0100, '0);
    idle(1);

    // multiplier ramp up to the cap
    for (int i = 0; i < 40; i++) step(4'b0001, 4'b0001);
    idle(1);

    // simultaneous hit and stray with combo 9
    step(4'b0100, '0);
    for (int i = 0; i < 9; i++) step(4'b0001, 4'b0001);
    step(4'b1001, 4'b0001);
    idle(1);

    // armed lane re-noted, with and without a press
    step('0, 4'b1000);
    idle(2);
    step(4'b1000, 4'b1000);
    idle(2);
    step('0, 4'b1000);
    idle(W + 1);

    // saturate score and combo
    for (int i = 0; i < 450; i++) step(4'b1111, 4'b1111);
    idle(2);

    // reset while a lane is armed
    step('0, 4'b0010);
    idle(2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    press = '0;
    note_due = '0;
    #1;
    chk_zero("async_reset");
    q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc++;
    idle(W + 4);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      logic [L-1:0] p, n;
      for (int i = 0; i < L; i++) begin
        n[i] = ($urandom_range(0, 9) == 0);
        p[i] = ($urandom_range(0, 5) == 0);
      end
      step(p, n);
    end
    idle(W + 3);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
